// File: rtl/riscv_pipe_pkg.sv
// Shared definitions for the pipelined core's hazard logic.
//   FWD_*        : E-stage operand mux selects (register file / writeback / memory)
//   waitState_t  : memory-wait watchdog states
//   WAIT_W       : width of the consecutive-wait counter (covers MAX_WAIT up to 2**16-1)
package riscv_pipe_pkg;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

    localparam int WAIT_W = 16;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_WAIT = 1'b1
    } waitState_t;

endpackage

// File: rtl/hazard_unit_mc_sat_counter.sv
// Saturating up-counter used for the hazard performance counters.
// Ports:
//   clk    in  clock, rising edge
//   reset  in  asynchronous active-high clear
//   inc    in  count one event this cycle
//   clr    in  synchronous clear; wins over a same-cycle inc
//   count  out current value, holds at all-ones instead of wrapping
module sat_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] count
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && (count != {W{1'b1}})) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/hazard_unit_mc.sv
// Hazard unit for the 5-stage pipeline with variable-latency data memory.
// Drives stage stalls/flushes and E-stage forwarding, watches for memory
// waits that run too long and counts hazard events.
// Ports:
//   clk, reset                       clock / async active-high reset
//   rs1_d, rs2_d                     sources of the instruction in D
//   rs1_e, rs2_e, rd_e               sources / destination in E
//   rd_m, regwrite_m                 destination / write enable in M
//   rd_w, regwrite_w                 destination / write enable in W
//   result_src_e0                    instruction in E is a load
//   pcsrc_e                          taken branch/jump resolved in E
//   mem_req_m, mem_ready             M-stage memory access and its completion
//   cnt_clr                          sync clear of counters and mem_timeout
//   stall_f/d/e/m, flush_d/e/w       pipeline register controls
//   forward_ae, forward_be           E operand mux selects
//   mem_timeout                      sticky: one wait reached MAX_WAIT cycles
//   lu_cnt, mw_cnt, fl_cnt           load-use stalls / wait cycles / branch flushes
//
// Watchdog states:
//   state   | meaning
//   ST_RUN  | no memory wait in progress, waitCnt = 0
//   ST_WAIT | memory wait in progress, waitCnt = waited cycles (saturating)
module hazard_unit_mc
    import riscv_pipe_pkg::*;
#(
    parameter int REG_AW   = 5,
    parameter int CNT_W    = 32,
    parameter int MAX_WAIT = 255
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [REG_AW-1:0] rs1_d,
    input  logic [REG_AW-1:0] rs2_d,
    input  logic [REG_AW-1:0] rs1_e,
    input  logic [REG_AW-1:0] rs2_e,
    input  logic [REG_AW-1:0] rd_e,
    input  logic [REG_AW-1:0] rd_m,
    input  logic [REG_AW-1:0] rd_w,
    input  logic              regwrite_m,
    input  logic              regwrite_w,
    input  logic              result_src_e0,
    input  logic              pcsrc_e,
    input  logic              mem_req_m,
    input  logic              mem_ready,
    input  logic              cnt_clr,
    output logic              stall_f,
    output logic              stall_d,
    output logic              stall_e,
    output logic              stall_m,
    output logic              flush_d,
    output logic              flush_e,
    output logic              flush_w,
    output logic [1:0]        forward_ae,
    output logic [1:0]        forward_be,
    output logic              mem_timeout,
    output logic [CNT_W-1:0]  lu_cnt,
    output logic [CNT_W-1:0]  mw_cnt,
    output logic [CNT_W-1:0]  fl_cnt
);

    localparam logic [WAIT_W-1:0] MAX_WAIT_V = WAIT_W'(MAX_WAIT);

    logic              memStall;
    logic              lwStall;
    logic [1:0]        fwdA;
    logic [1:0]        fwdB;
    waitState_t        state;
    waitState_t        nextState;
    logic [WAIT_W-1:0] waitCnt;
    logic [WAIT_W-1:0] nextWaitCnt;
    logic              timeoutQ;
    logic              nextTimeout;

    assign memStall = mem_req_m & ~mem_ready;

    // Load-use only matters when the pipe is moving; a memory wait freezes E anyway.
    assign lwStall = ~memStall & result_src_e0 & (rd_e != '0) &
                     ((rs1_d == rd_e) | (rs2_d == rd_e));

    always_comb begin
        fwdA = FWD_RF;
        if (regwrite_m && (rd_m != '0) && (rs1_e == rd_m)) begin
            fwdA = FWD_MEM;
        end else if (regwrite_w && (rd_w != '0) && (rs1_e == rd_w)) begin
            fwdA = FWD_WB;
        end
    end

    always_comb begin
        fwdB = FWD_RF;
        if (regwrite_m && (rd_m != '0) && (rs2_e == rd_m)) begin
            fwdB = FWD_MEM;
        end else if (regwrite_w && (rd_w != '0) && (rs2_e == rd_w)) begin
            fwdB = FWD_WB;
        end
    end

    // Outputs are forced low while reset is asserted so the datapath sees a
    // quiet hazard unit immediately, not only after the next edge.
    always_comb begin
        stall_f    = 1'b0;
        stall_d    = 1'b0;
        stall_e    = 1'b0;
        stall_m    = 1'b0;
        flush_d    = 1'b0;
        flush_e    = 1'b0;
        flush_w    = 1'b0;
        forward_ae = FWD_RF;
        forward_be = FWD_RF;
        if (!reset) begin
            forward_ae = fwdA;
            forward_be = fwdB;
            if (memStall) begin
                // Branch is held in frozen E and re-presents once memory completes.
                stall_f = 1'b1;
                stall_d = 1'b1;
                stall_e = 1'b1;
                stall_m = 1'b1;
                flush_w = 1'b1;
            end else begin
                stall_f = lwStall & ~pcsrc_e;
                stall_d = lwStall & ~pcsrc_e;
                flush_d = pcsrc_e;
                flush_e = lwStall | pcsrc_e;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= ST_RUN;
            waitCnt  <= '0;
            timeoutQ <= 1'b0;
        end else begin
            state    <= nextState;
            waitCnt  <= nextWaitCnt;
            timeoutQ <= nextTimeout;
        end
    end

    always_comb begin
        nextState   = state;
        nextWaitCnt = waitCnt;
        nextTimeout = timeoutQ;
        case (state)
            ST_RUN: begin
                if (memStall) begin
                    nextState   = ST_WAIT;
                    nextWaitCnt = WAIT_W'(1);
                end
            end
            ST_WAIT: begin
                if (memStall) begin
                    if (waitCnt != MAX_WAIT_V) begin
                        nextWaitCnt = waitCnt + 1'b1;
                    end
                end else begin
                    nextState   = ST_RUN;
                    nextWaitCnt = '0;
                end
            end
            default: begin
                nextState   = ST_RUN;
                nextWaitCnt = '0;
            end
        endcase
        // Set only on the edge the count arrives at the limit; the pipe stays frozen.
        if ((nextWaitCnt == MAX_WAIT_V) && (waitCnt != MAX_WAIT_V)) begin
            nextTimeout = 1'b1;
        end
        if (cnt_clr) begin
            nextTimeout = 1'b0;
        end
    end

    assign mem_timeout = timeoutQ;

    sat_counter #(.W(CNT_W)) uLuCnt (
        .clk   (clk),
        .reset (reset),
        .inc   (lwStall & ~pcsrc_e),
        .clr   (cnt_clr),
        .count (lu_cnt)
    );

    sat_counter #(.W(CNT_W)) uMwCnt (
        .clk   (clk),
        .reset (reset),
        .inc   (memStall),
        .clr   (cnt_clr),
        .count (mw_cnt)
    );

    sat_counter #(.W(CNT_W)) uFlCnt (
        .clk   (clk),
        .reset (reset),
        .inc   (pcsrc_e & ~memStall),
        .clr   (cnt_clr),
        .count (fl_cnt)
    );

endmodule

// File: tb/tb_hazard_unit_mc.sv
// Self-checking bench for hazard_unit_mc: directed scenarios followed by
// random traffic; a queue-based scoreboard decouples stimulus from checking.
module tb_hazard_unit_mc;

    localparam int REG_AW   = 5;
    localparam int CNT_W    = 3;
    localparam int MAX_WAIT = 4;
    localparam int CNT_MAX  = (1 << CNT_W) - 1;

    logic              clk = 1'b0;
    logic              reset;
    logic [REG_AW-1:0] rs1_d, rs2_d, rs1_e, rs2_e, rd_e, rd_m, rd_w;
    logic              regwrite_m, regwrite_w, result_src_e0, pcsrc_e;
    logic              mem_req_m, mem_ready, cnt_clr;
    logic              stall_f, stall_d, stall_e, stall_m;
    logic              flush_d, flush_e, flush_w;
    logic [1:0]        forward_ae, forward_be;
    logic              mem_timeout;
    logic [CNT_W-1:0]  lu_cnt, mw_cnt, fl_cnt;

    always #5 clk = ~clk;

    hazard_unit_mc #(.REG_AW(REG_AW), .CNT_W(CNT_W), .MAX_WAIT(MAX_WAIT)) dut (
        .clk(clk), .reset(reset),
        .rs1_d(rs1_d), .rs2_d(rs2_d), .rs1_e(rs1_e), .rs2_e(rs2_e),
        .rd_e(rd_e), .rd_m(rd_m), .rd_w(rd_w),
        .regwrite_m(regwrite_m), .regwrite_w(regwrite_w),
        .result_src_e0(result_src_e0), .pcsrc_e(pcsrc_e),
        .mem_req_m(mem_req_m), .mem_ready(mem_ready), .cnt_clr(cnt_clr),
        .stall_f(stall_f), .stall_d(stall_d), .stall_e(stall_e), .stall_m(stall_m),
        .flush_d(flush_d), .flush_e(flush_e), .flush_w(flush_w),
        .forward_ae(forward_ae), .forward_be(forward_be),
        .mem_timeout(mem_timeout),
        .lu_cnt(lu_cnt), .mw_cnt(mw_cnt), .fl_cnt(fl_cnt)
    );

    typedef struct {
        int sf, sd, se, sm, fd, fe, fw, fa, fb, to, lu, mw, fl;
    } exp_t;

    exp_t expQ[$];
    int   checks   = 0;
    int   failures = 0;

    // Reference model state: plain integers, not the RTL's encoding.
    int   mLu = 0, mMw = 0, mFl = 0, mWaited = 0, mTo = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d at t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic int fwdOf(input int rs);
        if (regwrite_m && rd_m != 0 && rs == int'(rd_m)) return 2;
        if (regwrite_w && rd_w != 0 && rs == int'(rd_w)) return 1;
        return 0;
    endfunction

    function automatic int satInc(input int v);
        return (v < CNT_MAX) ? v + 1 : v;
    endfunction

    // Compute expected response for the current inputs, queue it, then advance
    // the model across the coming clock edge.
    task automatic tick();
        exp_t e;
        int ms, lw, pc;
        if (reset) begin
            mLu = 0; mMw = 0; mFl = 0; mWaited = 0; mTo = 0;
            e = '{default: 0};
            expQ.push_back(e);
        end else begin
            ms = (mem_req_m && !mem_ready) ? 1 : 0;
            pc = pcsrc_e ? 1 : 0;
            lw = (!ms && result_src_e0 && rd_e != 0 &&
                  (rs1_d == rd_e || rs2_d == rd_e)) ? 1 : 0;
            e = '{default: 0};
            e.fa = fwdOf(int'(rs1_e));
            e.fb = fwdOf(int'(rs2_e));
            if (ms) begin
                e.sf = 1; e.sd = 1; e.se = 1; e.sm = 1; e.fw = 1;
            end else begin
                e.sf = lw & ~pc & 1; e.sd = e.sf;
                e.fd = pc;
                e.fe = lw | pc;
            end
            e.to = mTo; e.lu = mLu; e.mw = mMw; e.fl = mFl;
            expQ.push_back(e);
            if (ms) begin
                if (mWaited < MAX_WAIT) begin
                    mWaited++;
                    if (mWaited == MAX_WAIT) mTo = 1;
                end
            end else begin
                mWaited = 0;
            end
            if (cnt_clr) begin
                mLu = 0; mMw = 0; mFl = 0; mTo = 0;
            end else begin
                if (lw && !pc) mLu = satInc(mLu);
                if (ms)        mMw = satInc(mMw);
                if (e.fd != 0) mFl = satInc(mFl);
            end
        end
        @(posedge clk);
        #2;
    endtask

    task automatic idleIn();
        rs1_d = '0; rs2_d = '0; rs1_e = '0; rs2_e = '0;
        rd_e = '0; rd_m = '0; rd_w = '0;
        regwrite_m = 1'b0; regwrite_w = 1'b0; result_src_e0 = 1'b0;
        pcsrc_e = 1'b0; mem_req_m = 1'b0; mem_ready = 1'b0; cnt_clr = 1'b0;
    endtask

    // Monitor: every cycle presents a response; compare mid-cycle on the falling edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (expQ.size() != 0) begin
                e = expQ.pop_front();
                chk("stall_f", int'(stall_f), e.sf);
                chk("stall_d", int'(stall_d), e.sd);
                chk("stall_e", int'(stall_e), e.se);
                chk("stall_m", int'(stall_m), e.sm);
                chk("flush_d", int'(flush_d), e.fd);
                chk("flush_e", int'(flush_e), e.fe);
                chk("flush_w", int'(flush_w), e.fw);
                chk("forward_ae", int'(forward_ae), e.fa);
                chk("forward_be", int'(forward_be), e.fb);
                chk("mem_timeout", int'(mem_timeout), e.to);
                chk("lu_cnt", int'(lu_cnt), e.lu);
                chk("mw_cnt", int'(mw_cnt), e.mw);
                chk("fl_cnt", int'(fl_cnt), e.fl);
            end
        end
    end

    initial begin
        idleIn();
        reset = 1'b1;
        @(posedge clk);
        #2;
        tick();                         // reset state
        reset = 1'b0;
        tick();

        // Forwarding: M match, M+W match, rd_m = x0
        regwrite_m = 1'b1; rd_m = 5'd5; rs1_e = 5'd5; rs2_e = 5'd7;
        tick();
        regwrite_w = 1'b1; rd_w = 5'd5;
        tick();
        rd_m = 5'd0; regwrite_w = 1'b0;
        tick();
        regwrite_w = 1'b1; rd_w = 5'd7;
        tick();
        idleIn();

        // Load-use
        result_src_e0 = 1'b1; rd_e = 5'd6; rs2_d = 5'd6;
        tick();
        idleIn();
        tick();

        // Branch flush
        pcsrc_e = 1'b1;
        tick();
        idleIn();
        tick();

        // Memory wait with pending branch, then release
        mem_req_m = 1'b1; mem_ready = 1'b0; pcsrc_e = 1'b1;
        repeat (3) tick();
        mem_ready = 1'b1;
        tick();
        idleIn();
        tick();

        // Watchdog: 6 wait cycles against MAX_WAIT=4, then clear
        mem_req_m = 1'b1; mem_ready = 1'b0;
        repeat (6) tick();
        idleIn();
        repeat (2) tick();
        cnt_clr = 1'b1;
        tick();
        cnt_clr = 1'b0;
        tick();

        // Async reset in the middle of a wait
        mem_req_m = 1'b1; mem_ready = 1'b0; pcsrc_e = 1'b1;
        repeat (2) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        idleIn();
        tick();

        // Counter saturation: 9 flushes
        pcsrc_e = 1'b1;
        repeat (9) tick();
        idleIn();
        tick();

        // Random traffic on a small register range to provoke matches
        for (int i = 0; i < 400; i++) begin
            rs1_d = REG_AW'($urandom_range(0, 3));
            rs2_d = REG_AW'($urandom_range(0, 3));
            rs1_e = REG_AW'($urandom_range(0, 3));
            rs2_e = REG_AW'($urandom_range(0, 3));
            rd_e  = REG_AW'($urandom_range(0, 3));
            rd_m  = REG_AW'($urandom_range(0, 3));
            rd_w  = REG_AW'($urandom_range(0, 3));
            regwrite_m    = 1'($urandom_range(0, 1));
            regwrite_w    = 1'($urandom_range(0, 1));
            result_src_e0 = 1'($urandom_range(0, 1));
            pcsrc_e       = ($urandom_range(0, 3) == 0);
            mem_req_m     = ($urandom_range(0, 2) != 0);
            mem_ready     = ($urandom_range(0, 4) == 0);
            cnt_clr       = ($urandom_range(0, 39) == 0);
            reset         = ($urandom_range(0, 99) == 0);
            tick();
        end
        reset = 1'b0;
        idleIn();
        tick();

        @(negedge clk);
        #1;
        chk("scoreboard_drained", expQ.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
